data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares one data-memory channel among NUM_CONSUMERS per-thread LSU requesters using round-robin.
- Sits between a core's per-thread LSU data-memory ports and one external memory channel.
- Enforces the LSU-style handshake on both sides:
  - Valid is held until ready.
  - The requester drops valid after it sees ready.

Parameters:
- NUM_CONSUMERS, 4: number of LSU requesters (threads per block).
- ADDR_BITS, 8: data memory address width.
- DATA_BITS, 8: data memory word width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  per-consumer read address
- consumer_read_ready  out  NUM_CONSUMERS  per-consumer read complete
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  per-consumer returned data
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  per-consumer write complete
- mem_read_valid  out  1  channel read request
- mem_read_address  out  ADDR_BITS  channel read address
- mem_read_ready  in  1  channel read done, data valid
- mem_read_data  in  DATA_BITS  channel read data
- mem_write_valid  out  1  channel write request
- mem_write_address  out  ADDR_BITS  channel write address
- mem_write_data  out  DATA_BITS  channel write data
- mem_write_ready  in  1  channel write done

Behaviour:
- Reset: every output is 0, including all consumer_read_data. State=IDLE, rr_ptr=0, grant=0.
- State IDLE:
  - Scan consumers rr_ptr, rr_ptr+1, ... modulo NUM_CONSUMERS, skipping any whose ready is still high.
  - Select the first consumer with read_valid or write_valid.
  - If that consumer has both, read wins; the write is served on a later grant.
  - On selection, register grant.
  - Read: latch the address into mem_read_address, set mem_read_valid=1, go to READ_WAIT.
  - Write: latch address and data, set mem_write_valid=1, go to WRITE_WAIT.
  - mem_*_valid rises the cycle after the request is first sampled (1-cycle issue latency).
- State READ_WAIT:
  - Hold valid, address and data stable.
  - When mem_read_ready=1: mem_read_valid<=0, consumer_read_data[grant]<=mem_read_data, consumer_read_ready[grant]<=1, go to RELAY.
- State WRITE_WAIT: same pattern with mem_write_ready; drives consumer_write_ready[grant]<=1, go to RELAY.
- State RELAY:
  - Wait until the granted consumer's corresponding valid is 0.
  - Then clear its ready, set rr_ptr<=(grant+1) mod NUM_CONSUMERS, go to IDLE.
  - consumer_read_data[grant] holds its value until the next read completion for that consumer.
- Minimum turnaround per access is 4 cycles: issue, mem ready, consumer drop, idle.
- At most one transaction is outstanding. mem_read_valid and mem_write_valid are never both 1.
- Non-granted consumer requests stay pending, with no ready, until granted. A requester cannot be starved: with all requesters active, each waits at most NUM_CONSUMERS-1 grants.
- Consumer valid dropping while in READ_WAIT/WRITE_WAIT is ignored. The memory transaction completes and RELAY exits immediately.
- Wrap-around: rr_ptr wraps from NUM_CONSUMERS-1 to 0. Widths use $clog2(NUM_CONSUMERS), with a minimum of 1 bit.
- Asynchronous reset mid-transaction: the block returns to IDLE immediately and all valids/readies clear. Any in-flight memory transaction is abandoned.

Optional Feature:
- Macro: DATA_MEM_ARB_FIXED_PRIORITY_EN.
- Defined: the IDLE scan always starts at consumer 0, so the lowest index wins. rr_ptr is neither updated nor used.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package gpu_mem_pkg holds:
  - The state enum: IDLE=2'b00, READ_WAIT=2'b01, WRITE_WAIT=2'b10, RELAY=2'b11.
  - A localparam helper for the pointer width.
- One sub-module, rr_picker, is combinational. Inputs: request vector, rr_ptr. Outputs: found flag, grant index. It is reused later for program-memory arbitration.

Test Plan:
- Single read: consumer 2 reads 0x10, memory returns 0xAB after 3 cycles. mem_read_address=0x10; consumer_read_ready[2] rises 1 cycle after mem_read_ready; consumer_read_data[2]=0xAB.
- Single write: consumer 1 writes 0x5C to 0x20. mem_write_address=0x20, mem_write_data=0x5C; consumer_write_ready[1] pulses until valid drops.
- Contention: all 4 consumers issue reads in the same cycle. Grants occur in order 0,1,2,3; a consumer 0 re-request after its grant is served after 3.
- Same consumer, read and write both valid: the read is served first, then the write on a later grant. The memory valids never overlap.
- Reset asserted during READ_WAIT: all outputs are 0 immediately. After release, a new request is issued normally from rr_ptr=0.
- With DATA_MEM_ARB_FIXED_PRIORITY_EN defined, consumers 0 and 3 request continuously: consumer 0 wins every arbitration.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared types and helpers for the memory arbiters.
//   arb_state_t : arbiter FSM states (IDLE, READ_WAIT, WRITE_WAIT, RELAY)
//   ptr_bits()  : width of a consumer index / round-robin pointer (min 1 bit)
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    READ_WAIT  = 2'b01,
    WRITE_WAIT = 2'b10,
    RELAY      = 2'b11
  } arb_state_t;

  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: bundles the per-consumer LSU ports and the shared
// memory channel.
//   slave  : arbiter view (consumer requests and memory responses in)
//   master : environment view (core LSUs plus external memory)
interface data_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
  logic                                    mem_read_valid;
  logic [ADDR_BITS-1:0]                    mem_read_address;
  logic                                    mem_read_ready;
  logic [DATA_BITS-1:0]                    mem_read_data;
  logic                                    mem_write_valid;
  logic [ADDR_BITS-1:0]                    mem_write_address;
  logic [DATA_BITS-1:0]                    mem_write_data;
  logic                                    mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
           consumer_write_valid, consumer_write_address, consumer_write_data,
           mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
           mem_read_valid, mem_read_address,
           mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational rotating-priority search.
//   req    : request vector
//   rr_ptr : index searched first; the search wraps modulo N
//   found  : some request is set
//   idx    : first requesting index at or after rr_ptr
module rr_picker import gpu_mem_pkg::*; #(
  parameter int N  = 4,
  parameter int PW = ptr_bits(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic          found,
  output logic [PW-1:0] idx
);
  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_ptr) + i) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one data-memory channel among NUM_CONSUMERS LSU
// requesters, one transaction outstanding at a time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : consumer read/write ports and the memory channel (slave view)
// Build option: DATA_MEM_ARB_FIXED_PRIORITY_EN makes the scan always start at
// consumer 0 (lowest index wins) instead of round-robin.
module data_mem_arbiter import gpu_mem_pkg::*; #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input logic              clk,
  input logic              reset,
  data_mem_arbiter_if.slave bus
);
  localparam int PW = ptr_bits(NUM_CONSUMERS);
  localparam logic [PW-1:0] LAST = PW'(NUM_CONSUMERS - 1);

  arb_state_t                              state;
  logic [PW-1:0]                           grant, pick, scan_ptr;
  logic                                    found, op_read;
  logic [NUM_CONSUMERS-1:0]                req, rd_rdy, wr_rdy;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data;
  logic                                    mrv, mwv;
  logic [ADDR_BITS-1:0]                    mra, mwa;
  logic [DATA_BITS-1:0]                    mwd;

  // A consumer still holding ready is finishing its handshake; skip it.
  assign req = (bus.consumer_read_valid | bus.consumer_write_valid) & ~(rd_rdy | wr_rdy);

`ifdef DATA_MEM_ARB_FIXED_PRIORITY_EN
  assign scan_ptr = '0;
`else
  logic [PW-1:0] rr_ptr;
  assign scan_ptr = rr_ptr;
`endif

  rr_picker #(.N(NUM_CONSUMERS), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (scan_ptr),
    .found  (found),
    .idx    (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      op_read <= 1'b0;
      rd_rdy  <= '0;
      wr_rdy  <= '0;
      rd_data <= '0;
      mrv     <= 1'b0;
      mwv     <= 1'b0;
      mra     <= '0;
      mwa     <= '0;
      mwd     <= '0;
`ifndef DATA_MEM_ARB_FIXED_PRIORITY_EN
      rr_ptr  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          // Read wins when a consumer raises both; its write stays pending.
          if (bus.consumer_read_valid[pick]) begin
            op_read <= 1'b1;
            mra     <= bus.consumer_read_address[pick];
            mrv     <= 1'b1;
            state   <= READ_WAIT;
          end else begin
            op_read <= 1'b0;
            mwa     <= bus.consumer_write_address[pick];
            mwd     <= bus.consumer_write_data[pick];
            mwv     <= 1'b1;
            state   <= WRITE_WAIT;
          end
        end
        READ_WAIT: if (bus.mem_read_ready) begin
          mrv            <= 1'b0;
          rd_data[grant] <= bus.mem_read_data;
          rd_rdy[grant]  <= 1'b1;
          state          <= RELAY;
        end
        WRITE_WAIT: if (bus.mem_write_ready) begin
          mwv           <= 1'b0;
          wr_rdy[grant] <= 1'b1;
          state         <= RELAY;
        end
        RELAY: if (op_read ? !bus.consumer_read_valid[grant]
                           : !bus.consumer_write_valid[grant]) begin
          rd_rdy[grant] <= 1'b0;
          wr_rdy[grant] <= 1'b0;
`ifndef DATA_MEM_ARB_FIXED_PRIORITY_EN
          rr_ptr        <= (grant == LAST) ? '0 : grant + 1'b1;
`endif
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.consumer_read_ready  = rd_rdy;
  assign bus.consumer_read_data   = rd_data;
  assign bus.consumer_write_ready = wr_rdy;
  assign bus.mem_read_valid       = mrv;
  assign bus.mem_read_address     = mra;
  assign bus.mem_write_valid      = mwv;
  assign bus.mem_write_address    = mwa;
  assign bus.mem_write_data       = mwd;
endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int NC = 4, AB = 8, DB = 8, LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();
  data_mem_arbiter #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0, fails = 0, cyc_n = 0, rcnt = 0, wcnt = 0;
  logic [7:0] mem [256];
  int log_q[$];
  int log_cyc[$];
  bit auto_drop = 1'b1, overlap = 1'b0;

  // One clock of environment: memory responder (LAT cycles) and consumers
  // that drop valid once they see ready. Grants are logged as idx (read) or
  // NC+idx (write).
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (bus.mem_read_valid && bus.mem_write_valid) overlap = 1'b1;
    if (bus.mem_read_ready) bus.mem_read_ready = 1'b0;
    else if (bus.mem_read_valid) begin
      rcnt++;
      if (rcnt == LAT) begin
        rcnt = 0;
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = mem[bus.mem_read_address];
      end
    end
    if (bus.mem_write_ready) bus.mem_write_ready = 1'b0;
    else if (bus.mem_write_valid) begin
      wcnt++;
      if (wcnt == LAT) begin
        wcnt = 0;
        bus.mem_write_ready = 1'b1;
        mem[bus.mem_write_address] = bus.mem_write_data;
      end
    end
    if (auto_drop) for (int i = 0; i < NC; i++) begin
      if (bus.consumer_read_ready[i] && bus.consumer_read_valid[i]) begin
        bus.consumer_read_valid[i] = 1'b0; log_q.push_back(i); log_cyc.push_back(cyc_n);
      end
      if (bus.consumer_write_ready[i] && bus.consumer_write_valid[i]) begin
        bus.consumer_write_valid[i] = 1'b0; log_q.push_back(NC + i); log_cyc.push_back(cyc_n);
      end
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mem_valid: got %b%b want 00", bus.mem_read_valid, bus.mem_write_valid); end
    checks++; if (bus.consumer_read_ready !== 4'h0 || bus.consumer_write_ready !== 4'h0) begin
      fails++; $display("FAIL rst_ready: got %h/%h want 0/0", bus.consumer_read_ready, bus.consumer_write_ready); end
    checks++; if (bus.consumer_read_data !== 32'h0) begin
      fails++; $display("FAIL rst_rdata: got %h want 0", bus.consumer_read_data); end
    checks++; if (bus.mem_read_address !== 8'h0 || bus.mem_write_address !== 8'h0 || bus.mem_write_data !== 8'h0) begin
      fails++; $display("FAIL rst_mem_bus: got %h %h %h want 0", bus.mem_read_address, bus.mem_write_address, bus.mem_write_data); end
    reset = 1'b0;
    cyc();
    checks++; if (bus.mem_read_valid !== 1'b0) begin
      fails++; $display("FAIL rst_idle: got %b want 0", bus.mem_read_valid); end
  endtask

  task automatic test_single_read();
    int t_m;
    mem[8'h10] = 8'hAB;
    clear_log();
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2]   = 1'b1;
    checks++; if (bus.mem_read_valid !== 1'b0) begin
      fails++; $display("FAIL rd_pre_issue: got %b want 0", bus.mem_read_valid); end
    cyc();
    checks++; if (bus.mem_read_valid !== 1'b1) begin
      fails++; $display("FAIL rd_issue: got %b want 1", bus.mem_read_valid); end
    checks++; if (bus.mem_read_address !== 8'h10) begin
      fails++; $display("FAIL rd_addr: got %h want 10", bus.mem_read_address); end
    t_m = -1;
    for (int k = 0; k < 40 && log_q.size() == 0; k++) begin
      if (bus.mem_read_ready && t_m < 0) t_m = cyc_n;
      cyc();
    end
    checks++; if (log_q.size() != 1) begin
      fails++; $display("FAIL rd_done: got %0d grants want 1", log_q.size()); end
    else begin
      checks++; if (log_q[0] != 2) begin
        fails++; $display("FAIL rd_grant: got %0d want 2", log_q[0]); end
      checks++; if (log_cyc[0] != t_m + 1) begin
        fails++; $display("FAIL rd_ready_lat: got cyc %0d want %0d", log_cyc[0], t_m + 1); end
    end
    checks++; if (bus.consumer_read_data[2] !== 8'hAB) begin
      fails++; $display("FAIL rd_data: got %h want ab", bus.consumer_read_data[2]); end
    repeat (2) cyc();
    checks++; if (bus.consumer_read_ready[2] !== 1'b0 || bus.consumer_read_data[2] !== 8'hAB) begin
      fails++; $display("FAIL rd_release: got rdy %b data %h want 0 ab", bus.consumer_read_ready[2], bus.consumer_read_data[2]); end
  endtask

  task automatic test_single_write();
    int k;
    auto_drop = 1'b0;
    bus.consumer_write_address[1] = 8'h20;
    bus.consumer_write_data[1]    = 8'h5C;
    bus.consumer_write_valid[1]   = 1'b1;
    cyc();
    checks++; if (bus.mem_write_valid !== 1'b1 || bus.mem_read_valid !== 1'b0) begin
      fails++; $display("FAIL wr_issue: got w%b r%b want w1 r0", bus.mem_write_valid, bus.mem_read_valid); end
    checks++; if (bus.mem_write_address !== 8'h20 || bus.mem_write_data !== 8'h5C) begin
      fails++; $display("FAIL wr_bus: got %h/%h want 20/5c", bus.mem_write_address, bus.mem_write_data); end
    for (k = 0; k < 40 && !bus.consumer_write_ready[1]; k++) cyc();
    checks++; if (bus.consumer_write_ready[1] !== 1'b1) begin
      fails++; $display("FAIL wr_ready_timeout: got %b want 1", bus.consumer_write_ready[1]); end
    repeat (3) cyc();
    checks++; if (bus.consumer_write_ready[1] !== 1'b1 || bus.mem_write_valid !== 1'b0) begin
      fails++; $display("FAIL wr_ready_hold: got rdy %b wv %b want 1 0", bus.consumer_write_ready[1], bus.mem_write_valid); end
    checks++; if (mem[8'h20] !== 8'h5C) begin
      fails++; $display("FAIL wr_mem: got %h want 5c", mem[8'h20]); end
    bus.consumer_write_valid[1] = 1'b0;
    repeat (2) cyc();
    checks++; if (bus.consumer_write_ready[1] !== 1'b0) begin
      fails++; $display("FAIL wr_ready_clear: got %b want 0", bus.consumer_write_ready[1]); end
    auto_drop = 1'b1;
  endtask

  // rr_ptr is 2 here; a reset must bring it back to 0 so consumer 1 wins over 3.
  task automatic test_reset_mid();
    mem[8'h44] = 8'h12; mem[8'h48] = 8'h34;
    bus.consumer_read_address[2] = 8'h44;
    bus.consumer_read_valid[2]   = 1'b1;
    repeat (2) cyc();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.mem_read_valid !== 1'b0 || bus.consumer_read_ready !== 4'h0) begin
      fails++; $display("FAIL midrst_valid: got %b %h want 0 0", bus.mem_read_valid, bus.consumer_read_ready); end
    checks++; if (bus.consumer_read_data !== 32'h0 || bus.mem_read_address !== 8'h0) begin
      fails++; $display("FAIL midrst_data: got %h %h want 0 0", bus.consumer_read_data, bus.mem_read_address); end
    bus.consumer_read_valid = '0;
    bus.mem_read_ready = 1'b0;
    rcnt = 0;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    bus.consumer_read_address[1] = 8'h44;
    bus.consumer_read_address[3] = 8'h48;
    bus.consumer_read_valid[1] = 1'b1;
    bus.consumer_read_valid[3] = 1'b1;
    cyc();
    checks++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h44) begin
      fails++; $display("FAIL midrst_reissue: got %b %h want 1 44", bus.mem_read_valid, bus.mem_read_address); end
    for (int k = 0; k < 60 && log_q.size() < 2; k++) cyc();
    checks++; if (log_q.size() != 2) begin
      fails++; $display("FAIL midrst_timeout: got %0d grants want 2", log_q.size()); end
    else begin
      checks++; if (log_q[0] != 1 || log_q[1] != 3) begin
        fails++; $display("FAIL midrst_order: got %0d,%0d want 1,3", log_q[0], log_q[1]); end
    end
    checks++; if (bus.consumer_read_data[1] !== 8'h12 || bus.consumer_read_data[3] !== 8'h34) begin
      fails++; $display("FAIL midrst_data2: got %h %h want 12 34", bus.consumer_read_data[1], bus.consumer_read_data[3]); end
    repeat (2) cyc();
  endtask

  task automatic test_contention();
    int exp_q[5];
    bit rereq;
`ifdef DATA_MEM_ARB_FIXED_PRIORITY_EN
    exp_q = '{0, 0, 1, 2, 3};
`else
    exp_q = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < NC; i++) begin
      mem[8'h30 + i] = 8'h40 + 8'(i);
      bus.consumer_read_address[i] = 8'h30 + 8'(i);
    end
    clear_log();
    overlap = 1'b0;
    rereq = 1'b0;
    bus.consumer_read_valid = 4'hF;
    for (int k = 0; k < 200 && log_q.size() < 5; k++) begin
      cyc();
      if (!rereq && log_q.size() >= 1 && !bus.consumer_read_ready[0] && !bus.consumer_read_valid[0]) begin
        bus.consumer_read_valid[0] = 1'b1;
        rereq = 1'b1;
      end
    end
    checks++; if (log_q.size() != 5) begin
      fails++; $display("FAIL cont_timeout: got %0d grants want 5", log_q.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin
        fails++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, log_q[i], exp_q[i]); end
    end
    for (int i = 0; i < NC; i++) begin
      checks++; if (bus.consumer_read_data[i] !== 8'h40 + 8'(i)) begin
        fails++; $display("FAIL cont_data[%0d]: got %h want %h", i, bus.consumer_read_data[i], 8'h40 + 8'(i)); end
    end
    checks++; if (overlap !== 1'b0) begin
      fails++; $display("FAIL cont_overlap: got %b want 0", overlap); end
    repeat (2) cyc();
  endtask

  task automatic test_read_write_same();
    mem[8'h50] = 8'h99;
    clear_log();
    overlap = 1'b0;
    bus.consumer_read_address[3]  = 8'h50;
    bus.consumer_write_address[3] = 8'h60;
    bus.consumer_write_data[3]    = 8'h77;
    bus.consumer_read_valid[3]    = 1'b1;
    bus.consumer_write_valid[3]   = 1'b1;
    for (int k = 0; k < 60 && log_q.size() < 2; k++) cyc();
    checks++; if (log_q.size() != 2) begin
      fails++; $display("FAIL rw_timeout: got %0d grants want 2", log_q.size()); end
    else begin
      checks++; if (log_q[0] != 3 || log_q[1] != NC + 3) begin
        fails++; $display("FAIL rw_order: got %0d,%0d want 3,%0d", log_q[0], log_q[1], NC + 3); end
    end
    checks++; if (bus.consumer_read_data[3] !== 8'h99 || mem[8'h60] !== 8'h77) begin
      fails++; $display("FAIL rw_data: got %h %h want 99 77", bus.consumer_read_data[3], mem[8'h60]); end
    checks++; if (overlap !== 1'b0) begin
      fails++; $display("FAIL rw_overlap: got %b want 0", overlap); end
    repeat (2) cyc();
  endtask

  // Consumers 0 and 3 re-request forever; the last grant is abandoned by
  // dropping valid mid-transaction, which must still complete cleanly.
  task automatic test_priority();
    int exp_q[4];
`ifdef DATA_MEM_ARB_FIXED_PRIORITY_EN
    exp_q = '{0, 0, 0, 0};
`else
    exp_q = '{0, 3, 0, 3};
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.mem_read_ready = 1'b0; rcnt = 0;
    clear_log();
    bus.consumer_read_valid[0] = 1'b1;
    bus.consumer_read_valid[3] = 1'b1;
    for (int k = 0; k < 200 && log_q.size() < 4; k++) begin
      cyc();
      if (!bus.consumer_read_valid[0] && !bus.consumer_read_ready[0]) bus.consumer_read_valid[0] = 1'b1;
      if (!bus.consumer_read_valid[3] && !bus.consumer_read_ready[3]) bus.consumer_read_valid[3] = 1'b1;
    end
    bus.consumer_read_valid = '0;
    checks++; if (log_q.size() < 4) begin
      fails++; $display("FAIL prio_timeout: got %0d grants want 4", log_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (log_q[i] != exp_q[i]) begin
        fails++; $display("FAIL prio_order[%0d]: got %0d want %0d", i, log_q[i], exp_q[i]); end
    end
    repeat (12) cyc();
    checks++; if (bus.mem_read_valid !== 1'b0 || bus.consumer_read_ready !== 4'h0) begin
      fails++; $display("FAIL prio_drain: got %b %h want 0 0", bus.mem_read_valid, bus.consumer_read_ready); end
  endtask

  initial begin
    reset = 1'b1;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.mem_write_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_read();
    test_single_write();
    test_reset_mid();
    test_contention();
    test_read_write_same();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
